// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Arbiter FSM states; encodings are fixed so other blocks and benches can decode them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Width of the starvation counter. Equals $clog2(max_val+1) for any max_val >= 1;
    // a max_val of 0 still gets a 1-bit counter so the vector stays legal.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive data grants made while fetch was waiting.
// Latency: count updates on the clock after inc/clr; sat is a decode of the registered count.
// Backpressure: none; inc saturates at STARVE_MAX, clr has priority over inc.
//
// Ports: CLK, Reset (sync, active-high), inc (count one starving grant),
//        clr (return to zero), sat (count has reached STARVE_MAX).
module starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    import mem_arb_pkg::*;

    localparam int CNT_W = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data stages; data wins unless fetch is starved.
// Latency: request in cycle t drives m_req in t+1; done is combinational with m_ack (earliest t+1).
// Backpressure: requesters hold req until done; a slow memory (m_ack low) stalls the owner indefinitely.
//
// Ports: CLK, Reset (sync, active-high);
//        fetch side  i_req/i_addr in, i_done/i_rdata out;
//        data side   d_req/d_we/d_addr/d_wdata in, d_done/d_rdata out;
//        memory side m_req/m_we/m_addr/m_wdata out (registered), m_ack/m_rdata in;
//        gnt_i/gnt_d out (registered owner of the current transaction).
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              gnt_i,
    output logic              gnt_d
);
    import mem_arb_pkg::*;

    arb_state_e        state_d, state_q;
    logic              m_req_d, m_req_q;
    logic              m_we_d, m_we_q;
    logic [ADDR_W-1:0] m_addr_d, m_addr_q;
    logic [DATA_W-1:0] m_wdata_d, m_wdata_q;
    logic              gnt_i_d, gnt_i_q;
    logic              gnt_d_d, gnt_d_q;

    logic grant_d;
    logic grant_i;
    logic starve_sat;
    logic ack_i;
    logic ack_d;

    // Grants are only made from IDLE. Data has priority unless fetch is waiting
    // and has already been passed over STARVE_MAX times in a row.
    assign grant_d = (state_q == IDLE) && d_req && !(i_req && starve_sat);
    assign grant_i = (state_q == IDLE) && !grant_d && i_req;

    // An ack only completes a transaction while one is outstanding; acks in IDLE are dropped.
    assign ack_i = (state_q == BUSY_I) && m_ack;
    assign ack_d = (state_q == BUSY_D) && m_ack;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK   (CLK),
        .Reset (Reset),
        .inc   (grant_d && i_req),
        .clr   ((grant_d && !i_req) || grant_i),
        .sat   (starve_sat)
    );

    // State and output registers. Reset wins over every request and over m_ack.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            gnt_i_q   <= 1'b0;
            gnt_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            gnt_i_q   <= gnt_i_d;
            gnt_d_q   <= gnt_d_d;
        end
    end

    // Next state. Leaving BUSY always passes through IDLE, which guarantees a
    // cycle with m_req low between back-to-back transactions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I: begin
                if (m_ack) state_d = IDLE;
            end
            BUSY_D: begin
                if (m_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs: load the winner on a grant, hold while waiting for the ack,
    // drop the request and write enable once the ack arrives. Address and write data
    // are left as they were after completion.
    always_comb begin
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        gnt_i_d   = gnt_i_q;
        gnt_d_d   = gnt_d_q;
        if (grant_d) begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            gnt_i_d   = 1'b0;
            gnt_d_d   = 1'b1;
        end else if (grant_i) begin
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            gnt_i_d   = 1'b1;
            gnt_d_d   = 1'b0;
        end else if (ack_i || ack_d) begin
            m_req_d   = 1'b0;
            m_we_d    = 1'b0;
            gnt_i_d   = 1'b0;
            gnt_d_d   = 1'b0;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign gnt_i   = gnt_i_q;
    assign gnt_d   = gnt_d_q;

    // Completion is routed to the owner in the ack cycle; read data is zeroed otherwise.
    assign i_done  = ack_i;
    assign d_done  = ack_d;
    assign i_rdata = ack_i ? m_rdata : '0;
    assign d_rdata = ack_d ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a grant/done scoreboard and a simple memory responder.
// Latency: n/a.
// Backpressure: responder ack delay is programmable and can be held off to stretch transactions.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_ack;
    logic [63:0] m_rdata;
    logic        gnt_i;
    logic        gnt_d;

    mem_port_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (4)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } gnt_t;

    typedef struct {
        logic        is_d;
        logic [63:0] rdata;
    } done_t;

    gnt_t  gnt_q[$];
    done_t done_q[$];
    gnt_t  mon_g;
    done_t mon_d;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mem [logic [63:0]];
    int  hi_cnt;
    int  ack_wait;
    bit  ack_hold;
    bit  stray_ack;
    bit  d_keep;
    bit  saw_i_done = 1'b0;
    bit  saw_d_done = 1'b0;
    bit  m_req_prev = 1'b0;
    int  n_dg;
    bit  got_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_gnt(input logic is_d, input logic we, input logic [63:0] a, input logic [63:0] wd);
        gnt_t g;
        g.is_d = is_d; g.we = we; g.addr = a; g.wdata = wd;
        gnt_q.push_back(g);
    endtask

    task automatic exp_done(input logic is_d, input logic [63:0] rd);
        done_t e;
        e.is_d = is_d; e.rdata = rd;
        done_q.push_back(e);
    endtask

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // One clock: requesters drop after a done (unless told to keep going),
    // and the memory responder answers after ack_wait cycles of m_req.
    task automatic step();
        @(posedge CLK);
        #1;
        if (saw_i_done) i_req = 1'b0;
        if (saw_d_done && !d_keep) d_req = 1'b0;
        if (m_req === 1'b1) hi_cnt++; else hi_cnt = 0;
        m_ack   = stray_ack || ((m_req === 1'b1) && (hi_cnt > ack_wait) && !ack_hold);
        m_rdata = m_ack ? rd_mem(m_addr) : 64'h0;
        if (m_ack && (m_req === 1'b1) && (m_we === 1'b1)) mem[m_addr] = m_wdata;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            @(negedge CLK);
            if (gnt_q.size() == 0 && done_q.size() == 0 && !i_req && !d_req && dut.state_q == IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    // Scoreboard monitor: each new m_req must match the next expected grant,
    // each done must match the next expected completion.
    always @(negedge CLK) begin
        saw_i_done = (i_done === 1'b1);
        saw_d_done = (d_done === 1'b1);
        if ((m_req === 1'b1) && !m_req_prev) begin
            check("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
            if (gnt_q.size() != 0) begin
                mon_g = gnt_q.pop_front();
                check("gnt_owner", 64'({gnt_i, gnt_d}), 64'({~mon_g.is_d, mon_g.is_d}));
                check("gnt_we", 64'(m_we), 64'(mon_g.we));
                check("gnt_addr", m_addr, mon_g.addr);
                check("gnt_wdata", m_wdata, mon_g.wdata);
            end
        end
        if ((i_done === 1'b1) || (d_done === 1'b1)) begin
            check("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) begin
                mon_d = done_q.pop_front();
                check("done_port", 64'({i_done, d_done}), 64'({~mon_d.is_d, mon_d.is_d}));
                check("done_rdata", mon_d.is_d ? d_rdata : i_rdata, mon_d.rdata);
                check("idle_rdata", mon_d.is_d ? i_rdata : d_rdata, 64'h0);
            end
        end
        m_req_prev = (m_req === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; i_req = 1'b1; i_addr = 64'h999; d_req = 1'b1; d_we = 1'b1;
        d_addr = 64'h998; d_wdata = 64'h1234; m_ack = 1'b0; m_rdata = 64'h0;
        hi_cnt = 0; ack_wait = 1; ack_hold = 1'b0; stray_ack = 1'b0; d_keep = 1'b0;
        mem[64'h40]  = 64'h8B020020;
        mem[64'h80]  = 64'h8080;
        mem[64'h100] = 64'h5555;
        mem[64'h200] = 64'h2222;
        mem[64'h300] = 64'h3333;
        mem[64'h400] = 64'h4444;
        mem[64'h600] = 64'h6666;

        // Reset with both requesters active: nothing may be issued.
        step(); step();
        @(negedge CLK);
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        check("rst_ctl", 64'({m_req, m_we, gnt_i, gnt_d, i_done, d_done}), 64'd0);
        check("rst_addr", m_addr, 64'h0);
        check("rst_wdata", m_wdata, 64'h0);
        check("rst_cnt", 64'(dut.u_starve.cnt_q), 64'd0);
        step();
        Reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0;

        // Single fetch, ack one cycle after m_req.
        step();
        i_req = 1'b1; i_addr = 64'h40;
        exp_gnt(1'b0, 1'b0, 64'h40, 64'h0);
        exp_done(1'b0, 64'h8B020020);
        @(negedge CLK);
        check("f_t0_mreq", 64'(m_req), 64'd0);
        step(); @(negedge CLK);
        check("f_t1_ctl", 64'({gnt_i, gnt_d, m_req, m_we, i_done}), 64'b10100);
        check("f_t1_addr", m_addr, 64'h40);
        step(); @(negedge CLK);
        check("f_t2_done", 64'({i_done, d_done}), 64'b10);
        check("f_t2_rdata", i_rdata, 64'h8B020020);
        step(); @(negedge CLK);
        check("f_t3_state", 64'(dut.state_q), 64'(IDLE));
        check("f_t3_ctl", 64'({m_req, i_done, d_done}), 64'd0);

        // Simultaneous requests: store wins, fetch follows after one IDLE cycle.
        ack_wait = 0;
        i_req = 1'b1; i_addr = 64'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD;
        exp_gnt(1'b1, 1'b1, 64'h100, 64'hDEAD);
        exp_done(1'b1, 64'h5555);
        exp_gnt(1'b0, 1'b0, 64'h80, 64'h0);
        exp_done(1'b0, 64'h8080);
        step(); @(negedge CLK);
        check("s_ctl", 64'({gnt_i, gnt_d, m_we, i_done, d_done}), 64'b01101);
        check("s_addr", m_addr, 64'h100);
        check("s_wdata", m_wdata, 64'hDEAD);
        check("s_cnt_inc", 64'(dut.u_starve.cnt_q), 64'd1);
        step(); @(negedge CLK);
        check("s_gap", 64'({m_req, i_done, d_done}), 64'd0);
        step(); @(negedge CLK);
        check("s_fetch_ctl", 64'({gnt_i, gnt_d, m_we, i_done}), 64'b1001);
        check("s_fetch_wdata", m_wdata, 64'h0);
        check("s_cnt_clr", 64'(dut.u_starve.cnt_q), 64'd0);
        step(); @(negedge CLK);
        check("s_end_state", 64'(dut.state_q), 64'(IDLE));

        // Starvation: data requests every IDLE while fetch waits.
        i_req = 1'b1; i_addr = 64'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; d_wdata = 64'h77; d_keep = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt(1'b1, 1'b0, 64'h100, 64'h77);
            exp_done(1'b1, 64'hDEAD);
        end
        exp_gnt(1'b0, 1'b0, 64'h200, 64'h0);
        exp_done(1'b0, 64'h2222);
        n_dg = 0; got_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(); @(negedge CLK);
            if (gnt_d === 1'b1 && d_done === 1'b1) begin
                n_dg++;
                if (n_dg == 4) check("st_cnt_sat", 64'(dut.u_starve.cnt_q), 64'd4);
            end
            if (gnt_i === 1'b1 && i_done === 1'b1) begin
                got_i = 1'b1;
                check("st_data_grants", 64'(n_dg), 64'd4);
                check("st_cnt_clr", 64'(dut.u_starve.cnt_q), 64'd0);
                break;
            end
        end
        check("st_fetch_seen", 64'(got_i), 64'd1);
        step();
        d_req = 1'b0; d_keep = 1'b0;
        @(negedge CLK);
        check("st_end_state", 64'(dut.state_q), 64'(IDLE));

        // Stretched ack on a store; fetch queues up behind it.
        ack_hold = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h300; d_wdata = 64'hBEEF;
        exp_gnt(1'b1, 1'b1, 64'h300, 64'hBEEF);
        exp_done(1'b1, 64'h3333);
        step();
        i_req = 1'b1; i_addr = 64'h400;
        exp_gnt(1'b0, 1'b0, 64'h400, 64'h0);
        exp_done(1'b0, 64'h4444);
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            check("str_ctl", 64'({gnt_d, m_req, m_we, i_done, d_done}), 64'b11100);
            check("str_addr", m_addr, 64'h300);
            check("str_wdata", m_wdata, 64'hBEEF);
            if (k == 6) ack_hold = 1'b0;
            step();
        end
        @(negedge CLK);
        check("str_done", 64'({i_done, d_done}), 64'b01);
        run_until_idle("str_drain", 20);

        // Reset in the middle of a store: aborted, and a later ack completes nothing.
        ack_hold = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'hAAAA;
        exp_gnt(1'b1, 1'b1, 64'h500, 64'hAAAA);
        step(); @(negedge CLK);
        check("rm_busy", 64'(dut.state_q), 64'(BUSY_D));
        Reset = 1'b1; d_req = 1'b0;
        step(); @(negedge CLK);
        check("rm_state", 64'(dut.state_q), 64'(IDLE));
        check("rm_ctl", 64'({m_req, m_we, gnt_d, gnt_i, i_done, d_done}), 64'd0);
        check("rm_addr", m_addr, 64'h0);
        Reset = 1'b0; ack_hold = 1'b0; stray_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(); @(negedge CLK);
            check("stray_ack_seen", 64'(m_ack), 64'd1);
            check("stray_done", 64'({i_done, d_done, m_req}), 64'd0);
            check("stray_state", 64'(dut.state_q), 64'(IDLE));
        end
        stray_ack = 1'b0;

        // Requester drops d_req mid-transaction: transaction still completes with done.
        ack_hold = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600; d_wdata = 64'h0;
        exp_gnt(1'b1, 1'b0, 64'h600, 64'h0);
        exp_done(1'b1, 64'h6666);
        step();
        d_req = 1'b0;
        step();
        ack_hold = 1'b0;
        step(); @(negedge CLK);
        check("drop_done", 64'({i_done, d_done}), 64'b01);
        check("drop_rdata", d_rdata, 64'h6666);
        run_until_idle("drop_drain", 10);

        repeat (3) step();
        @(negedge CLK);
        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the address width.
REQ-002 Parameter DATA_W, default 64, SHALL set the data width.
REQ-003 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive data grants while fetch waits.
REQ-004 Port CLK, input, 1: single clock; all state SHALL update on posedge CLK.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port i_req, input, 1: fetch requests a read; held high until i_done.
REQ-007 Port i_addr, input, ADDR_W: fetch address; stable while i_req is high.
REQ-008 Port i_done, output, 1: fetch transaction complete.
REQ-009 Port i_rdata, output, DATA_W: fetch read data, valid with i_done.
REQ-010 Port d_req, input, 1: data-stage request; held high until d_done.
REQ-011 Port d_we, input, 1: 1 = store, 0 = load; stable while d_req is high.
REQ-012 Port d_addr, input, ADDR_W: data address.
REQ-013 Port d_wdata, input, DATA_W: store data.
REQ-014 Port d_done, output, 1: data transaction complete.
REQ-015 Port d_rdata, output, DATA_W: load data, valid with d_done.
REQ-016 Port m_req, output, 1: registered request to the single-ported memory.
REQ-017 Port m_we, output, 1: registered write enable.
REQ-018 Port m_addr, output, ADDR_W: registered memory address.
REQ-019 Port m_wdata, output, DATA_W: registered memory write data.
REQ-020 Port m_ack, input, 1: memory completes the transaction; m_rdata is valid in the same cycle.
REQ-021 Port m_rdata, input, DATA_W: memory read data.
REQ-022 Port gnt_i, output, 1: registered; owner is fetch.
REQ-023 Port gnt_d, output, 1: registered; owner is data.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-025 In IDLE with d_req=1, and not (i_req=1 and starve_cnt==STARVE_MAX), the next state SHALL be BUSY_D.
REQ-026 In IDLE where REQ-025 does not apply and i_req=1, the next state SHALL be BUSY_I.
REQ-027 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-028 On a grant, m_addr/m_we/m_wdata SHALL latch the winner's inputs, m_req SHALL be 1, and the matching gnt SHALL be 1, all from the next cycle.
- Fetch grants set m_we=0 and m_wdata=0.
REQ-029 In BUSY_x, m_ack=1 SHALL assert x_done combinationally in the same cycle, with x_rdata=m_rdata, and the next state SHALL be IDLE.
REQ-030 i_done and d_done SHALL be 0 whenever the FSM is not in the matching BUSY state; i_rdata and d_rdata SHALL then be 0.
REQ-031 In BUSY_x with m_ack=0, the FSM SHALL hold the state and all m_* outputs unchanged, with no timeout.
REQ-032 m_ack seen in IDLE SHALL be ignored.
REQ-033 Minimum latency: req at cycle t gives m_req at t+1; m_ack at t+1 gives done at t+1.
REQ-034 Back-to-back transactions SHALL be separated by at least one IDLE cycle with m_req=0.
REQ-035 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant made while i_req=1.
REQ-036 starve_cnt SHALL clear on a data grant made while i_req=0, and on every fetch grant.
REQ-037 Counter width SHALL be $clog2(STARVE_MAX+1).
REQ-038 A requester that deasserts req mid-transaction is a protocol violation.
- The arbiter SHALL complete the memory transaction regardless and still pulse done.

Reset
REQ-039 While Reset=1 at posedge CLK, the following SHALL be forced:
- state to IDLE, starve_cnt to 0;
- m_req, m_we, gnt_i, gnt_d to 0;
- m_addr and m_wdata to 0.
REQ-040 Reset SHALL take priority over m_ack and all requests, including mid-transaction.
- i_done and d_done SHALL be 0 from the cycle after reset is sampled.
- No memory write SHALL be issued after reset.

Structure
REQ-041 State encodings (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) SHALL live in a shared package header, mem_arb_pkg, for reuse by the processor top and benches.
REQ-042 The starvation counter SHALL be a sub-module, starve_counter, with ports inc, clr, sat.
- The FSM and output registers SHALL remain in mem_port_arbiter.

Verification
REQ-043 Single fetch: i_req=1, i_addr=0x40, m_ack one cycle after m_req, m_rdata=0x8B020020 -> m_req/gnt_i at t+1; i_done=1 with i_rdata=0x8B020020 at t+2; IDLE at t+3.
REQ-044 Simultaneous: i_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD -> data granted first, m_we=1, m_addr=0x100, m_wdata=0xDEAD; fetch granted after d_done.
REQ-045 Starvation: i_req held, d_req re-asserted every IDLE, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
REQ-046 Stretched ack: m_ack held low 7 cycles in BUSY_D -> m_* stable for all 7 cycles, d_done=0, i_done=0 throughout.
REQ-047 Reset mid-transaction: Reset=1 for one cycle in BUSY_D with d_we=1 -> next cycle IDLE, m_req=0, m_we=0, gnt_d=0; a later m_ack produces no done.
REQ-048 Stray ack: m_ack=1 in IDLE with no requests -> i_done=d_done=0 and the state remains IDLE.
